// File: rtl/fp_xx.sv
// -----------------------------------------------------------------------------
// fp_xx - IEEE-754 binary32 adder/subtractor, round-to-nearest-even, with a
// registered result (one-cycle latency, one operation per cycle).
//
// Ports
//   clk  : system clock, rising-edge active
//   rst  : asynchronous active-low reset; forces c to 0 while low
//   a    : operand A, binary32
//   b    : operand B, binary32
//   op   : 0 = c = a + b, 1 = c = a - b
//   c    : registered binary32 result
//
// Build option
//   FP_XX_DENORM_EN : when defined, subnormal inputs and results are handled
//                     with gradual underflow. When undefined, subnormal inputs
//                     read as signed zero and subnormal results flush to a
//                     signed zero.
// -----------------------------------------------------------------------------
module fp_xx (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] c
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Returns the number of leading zeros of a 27-bit value (27 when all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Field extraction and classification
  // ---------------------------------------------------------------------------
  logic        sa, sb_eff;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf;

  assign sa     = a[31];
  assign sb_eff = b[31] ^ op;
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];

  assign a_nan = (&ea) & (|fa);
  assign b_nan = (&eb) & (|fb);
  assign a_inf = (&ea) & ~(|fa);
  assign b_inf = (&eb) & ~(|fb);

  // Unpacked mantissa (hidden bit explicit) and effective exponent.
  logic [23:0] ma, mb;
  logic [7:0]  xa, xb;

`ifdef FP_XX_DENORM_EN
  // Subnormals carry a 0 hidden bit and behave as if their exponent were 1.
  assign ma = {|ea, fa};
  assign mb = {|eb, fb};
  assign xa = (ea == 8'd0) ? 8'd1 : ea;
  assign xb = (eb == 8'd0) ? 8'd1 : eb;
`else
  // Subnormals are flushed: zero mantissa, zero exponent.
  assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
  assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, fb};
  assign xa = ea;
  assign xb = eb;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: swap, align, add/subtract, normalize, round, pack
  // ---------------------------------------------------------------------------
  logic        a_big, sub, sl;
  logic [7:0]  el, es, ediff, shamt;
  logic [23:0] ml, msm;
  logic [49:0] ext;
  logic [26:0] aligned, mlx, dif, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_n, exp_f;
  logic        mag_zero, rnd_up;
  logic [24:0] rounded;
  logic [22:0] frac;
  logic [31:0] c_d;

  // NOTE: every variable assigned in this block gets a value at the top, so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    a_big    = 1'b1;
    sl       = 1'b0;
    el       = 8'd0;
    es       = 8'd0;
    ml       = 24'd0;
    msm      = 24'd0;
    ediff    = 8'd0;
    ext      = 50'd0;
    aligned  = 27'd0;
    mlx      = 27'd0;
    sum      = 28'd0;
    dif      = 27'd0;
    lz       = 5'd0;
    shamt    = 8'd0;
    norm     = 27'd0;
    e_n      = 10'd0;
    mag_zero = 1'b0;
    rnd_up   = 1'b0;
    rounded  = 25'd0;
    exp_f    = 10'd0;
    frac     = 23'd0;
    c_d      = 32'd0;

    sub = sa ^ sb_eff;

    // Larger magnitude first: exponent compared before mantissa.
    a_big = ({xa, ma} >= {xb, mb});
    if (a_big) begin
      sl = sa;     el = xa; ml = ma;
      es = xb;     msm = mb;
    end else begin
      sl = sb_eff; el = xb; ml = mb;
      es = xa;     msm = ma;
    end

    // Align: 24 mantissa bits + guard + round + sticky.
    ediff = el - es;
    ext   = {msm, 26'd0} >> ediff;
    if (ediff >= 8'd27) aligned = {26'd0, |msm};
    else                aligned = {ext[49:24], |ext[23:0]};

    mlx = {ml, 3'b000};
    sum = {1'b0, mlx} + {1'b0, aligned};
    dif = mlx - aligned;
    lz  = lzc27(dif);

    if (!sub) begin
      mag_zero = (sum == 28'd0);
      if (sum[27]) begin
        // Carry-out: shift right one, folding the dropped bit into sticky.
        norm = {sum[27:2], sum[1] | sum[0]};
        e_n  = {2'b00, el} + 10'd1;
      end else begin
        norm = sum[26:0];
        e_n  = {2'b00, el};
      end
    end else begin
      mag_zero = (dif == 27'd0);
      // Left shift stops at exponent 1; a leading 0 left over marks a
      // subnormal result. When lz >= 2 the sticky bit is necessarily 0, so
      // shifting it up with the rest is exact.
      if ({3'b000, lz} < el) shamt = {3'b000, lz};
      else if (el != 8'd0)   shamt = el - 8'd1;
      else                   shamt = 8'd0;
      norm = dif << shamt;
      e_n  = {2'b00, el} - {2'b00, shamt};
    end

    // Round to nearest, ties to even.
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    if (rounded[24]) begin
      exp_f = e_n + 10'd1;
      frac  = rounded[23:1];
    end else if (rounded[23]) begin
      // Also covers a subnormal rounding up into the minimum normal.
      exp_f = e_n;
      frac  = rounded[22:0];
    end else begin
      exp_f = 10'd0;
      frac  = rounded[22:0];
    end

    if (a_nan || b_nan)                       c_d = QNAN;
    else if (a_inf && b_inf && (sa != sb_eff)) c_d = QNAN;
    else if (a_inf)                           c_d = {sa, 8'hFF, 23'd0};
    else if (b_inf)                           c_d = {sb_eff, 8'hFF, 23'd0};
    else if (mag_zero)                        c_d = sub ? 32'd0 : {sl, 31'd0};
    else if (exp_f >= 10'd255)                c_d = {sl, 8'hFF, 23'd0};
`ifndef FP_XX_DENORM_EN
    else if (exp_f == 10'd0)                  c_d = {sl, 31'd0};
`endif
    else                                      c_d = {sl, exp_f[7:0], frac};
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples its D input from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) c <= 32'd0;
    else      c <= c_d;
  end

endmodule

// File: tb/tb_fp_xx.sv
// -----------------------------------------------------------------------------
// tb_fp_xx - self-checking bench for fp_xx. Directed vectors with fixed
// expected results, then randomized operands checked against an exact-integer
// reference model (operands scaled to units of 2^-149, summed exactly, then
// rounded to binary32).
// -----------------------------------------------------------------------------
module tb_fp_xx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        op_in = 1'b0;
  logic [31:0] c;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  fp_xx dut (
    .clk (clk),
    .rst (rst),
    .a   (a_in),
    .b   (b_in),
    .op  (op_in),
    .c   (c)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [299:0] mag_of(input logic [31:0] x);
    logic [299:0] m;
    if (x[30:23] == 8'd0) begin
`ifdef FP_XX_DENORM_EN
      m = {277'd0, x[22:0]};
`else
      m = 300'd0;
`endif
    end else begin
      m = {276'd0, 1'b1, x[22:0]};
      m = m << (int'(x[30:23]) - 1);
    end
    return m;
  endfunction

  function automatic logic [31:0] ref_fp(input logic [31:0] x, input logic [31:0] y,
                                         input logic o);
    logic         sx, sy, sr;
    logic         x_nan, y_nan, x_inf, y_inf;
    logic [299:0] mx, my, mag, rem, half;
    logic [24:0]  keep;
    int           p, sh, e;
    sx    = x[31];
    sy    = y[31] ^ o;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (x_nan || y_nan)              return QNAN;
    if (x_inf && y_inf && (sx != sy)) return QNAN;
    if (x_inf)                       return {sx, 8'hFF, 23'd0};
    if (y_inf)                       return {sy, 8'hFF, 23'd0};
    mx = mag_of(x);
    my = mag_of(y);
    if (sx == sy)      begin mag = mx + my; sr = sx; end
    else if (mx >= my) begin mag = mx - my; sr = sx; end
    else               begin mag = my - mx; sr = sy; end
    if (mag == 300'd0) return (sx == sy) ? {sx, 31'd0} : 32'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) begin
`ifdef FP_XX_DENORM_EN
      return {sr, 8'd0, mag[22:0]};
`else
      return {sr, 31'd0};
`endif
    end
    sh   = p - 23;
    keep = 25'(mag >> sh);
    e    = p - 22;
    if (sh > 0) begin
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 25'd1;
    end
    if (keep[24]) begin keep = keep >> 1; e = e + 1; end
    if (e >= 255) return {sr, 8'hFF, 23'd0};
    return {sr, 8'(e), keep[22:0]};
  endfunction

  // Random operand, biased toward interesting regions relative to 'other'.
  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] r;
    logic [7:0]  ex;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2: ;
      3: begin
        ex = other[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
        r  = {r[31], ex, r[22:0]};
      end
      4: r = {r[31], 8'd0, r[22:0]};
      5: case ($urandom_range(0, 4))
           0: r = {r[31], 8'hFF, 23'd0};
           1: r = {r[31], 8'hFF, r[22:1], 1'b1};
           2: r = {r[31], 31'd0};
           3: r = {r[31], 8'hFE, r[22:0]};
           default: r = {r[31], 8'd1, r[22:0]};
         endcase
      6: r = {r[31], other[30:0] ^ 31'($urandom_range(0, 7))};
      default: r = {r[31], 8'($urandom_range(0, 30)), r[22:0]};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] expected);
    tests++;
    assert (c === expected)
    else begin
      fails++;
      $error("FAIL %s: a=%h b=%h op=%b c=%h expected %h",
             tag, a_in, b_in, op_in, c, expected);
    end
  endtask

  // Drive between edges, let one rising edge capture, sample 1 time unit later.
  task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic ov);
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    op_in = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic ov, input logic [31:0] expected);
    step(av, bv, ov);
    check(tag, expected);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra, rb;
    logic        ro;

    // Reset state, held across an edge with inputs that would give nonzero.
    a_in = 32'h3F80_0000; b_in = 32'h3F80_0000;
    #3;
    check("reset_initial", 32'd0);
    @(posedge clk); #1;
    check("reset_held", 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic add
    vec("add_1_1",     32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
    vec("add_4_m7",    32'h4080_0000, 32'hC0E0_0000, 1'b0, 32'hC040_0000);
    vec("add_m10_m10", 32'hC120_0000, 32'hC120_0000, 1'b0, 32'hC1A0_0000);

    // Cancellation and subtract
    vec("cancel_pos0", 32'hC120_0000, 32'h4120_0000, 1'b0, 32'h0000_0000);
    vec("sub_10_5",    32'h4120_0000, 32'h40A0_0000, 1'b1, 32'h40A0_0000);
    vec("sub_7_m4",    32'h40E0_0000, 32'hC080_0000, 1'b1, 32'h4130_0000);
    vec("sub_m4_7",    32'hC080_0000, 32'h40E0_0000, 1'b1, 32'hC130_0000);

    // Rounding
    vec("rne_tie",     32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    vec("rne_above",   32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001);

    // Specials
    vec("inf_m_inf",   32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
    vec("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    vec("nan_in",      32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
    vec("negz_negz",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    vec("inf_finite",  32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);

    // Underflow
`ifdef FP_XX_DENORM_EN
    vec("subnormal",   32'h0080_0000, 32'h0040_0000, 1'b1, 32'h0040_0000);
    vec("sub_plus_sub",32'h0040_0000, 32'h0040_0000, 1'b0, 32'h0080_0000);
`else
    vec("ftz_result",  32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000);
    vec("ftz_neg",     32'h8080_0001, 32'h8080_0000, 1'b1, 32'h8000_0000);
`endif

    // Asynchronous reset between edges, then recovery.
    step(32'h4000_0000, 32'h4000_0000, 1'b0);
    check("pre_reset", 32'h4080_0000);
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", 32'd0);
    @(negedge clk);
    rst = 1'b1;
    vec("post_reset",  32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);

    // Randomized operands against the reference model.
    for (int n = 0; n < 800; n++) begin
      ra = rand_op($urandom);
      rb = rand_op(ra);
      ro = 1'($urandom_range(0, 1));
      step(ra, rb, ro);
      check("rand", ref_fp(ra, rb, ro));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
